seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment scan controller, the successor to the fixed 8-digit hex display driver. It time-multiplexes NUM_DIGITS hex digits onto shared segment lines. Over the old driver it adds:
- a frame-synchronous data snapshot, so a frame never tears
- an inter-digit blanking gap against ghosting
- 16-level brightness PWM
- per-digit decimal point and blank masks
- leading-zero blanking
- configurable output polarity

It sits between the frequency-counter BCD/hex result logic and the board display pins.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_decode.sv | 16 +
 rtl/seg7_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg7_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value (entry 0 is rightmost).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

    typedef enum logic [1:0] {GAP, ON, OFF} scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Nibble + decimal point to 8 segment lines, {dp,g..a}, in the requested polarity.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);
    logic [7:0] seg_al;

    assign seg_al = {~dp, HEX_SEG[nib]};
    assign seg    = ACTIVE_LOW ? seg_al : ~seg_al;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex display scanner: frame snapshot, blanking gap,
// 16-level PWM brightness, dp/blank masks and leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int GAP_CYCLES     = 500,
    parameter int PHASE_CYCLES   = 3000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [4*NUM_DIGITS-1:0] Disp_Data,
    input  logic [NUM_DIGITS-1:0]   Dp_Mask,
    input  logic [NUM_DIGITS-1:0]   Blank_Mask,
    input  logic                    Lz_En,
    input  logic [3:0]              Bright,
    output logic [NUM_DIGITS-1:0]   SEL,
    output logic [7:0]              SEG,
    output logic                    Frame_Done
);
    localparam int SLOT = GAP_CYCLES + 16 * PHASE_CYCLES;
    localparam int CW   = $clog2(SLOT);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF =
        SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_ALL_OFF : ~SEG_ALL_OFF;

    logic [CW-1:0]              slot_cnt, cnt_nxt;
    logic [IW-1:0]              dig_idx;
    scan_state_e                state, state_nxt;
    logic                       slot_end, frame_start, lit;
    logic [31:0]                on_end;
    logic [NUM_DIGITS-1:0][3:0] data_s;
    logic [NUM_DIGITS-1:0]      dp_s, blank_s, zrun, dark;
    logic                       lz_s;
    logic [3:0]                 bright_s;
    logic [NUM_DIGITS-1:0][7:0] dig_seg;

    assign slot_end    = (slot_cnt == CW'(SLOT - 1));
    assign cnt_nxt     = slot_end ? '0 : slot_cnt + CW'(1);
    assign frame_start = (slot_cnt == '0) && (dig_idx == '0);
    // First slot count past the lit window: GAP + (Bright+1) phases.
    assign on_end      = 32'(GAP_CYCLES) + (32'(bright_s) + 32'd1) * 32'(PHASE_CYCLES);

    always_comb begin
        state_nxt = state;
        case (state)
            GAP: if (32'(cnt_nxt) == 32'(GAP_CYCLES)) state_nxt = ON;
            ON: begin
                if (cnt_nxt == '0)                  state_nxt = GAP;
                else if (32'(cnt_nxt) == on_end)    state_nxt = OFF;
            end
            OFF: if (cnt_nxt == '0) state_nxt = GAP;
            default: state_nxt = GAP;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset || !Enable) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            state    <= GAP;
        end else begin
            slot_cnt <= cnt_nxt;
            state    <= state_nxt;
            if (slot_end)
                dig_idx <= (dig_idx == IW'(NUM_DIGITS - 1)) ? '0 : dig_idx + IW'(1);
        end
    end

    // Shadows hold through Enable=0 so a disabled display keeps its last frame's data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_s   <= '0;
            dp_s     <= '0;
            blank_s  <= '0;
            lz_s     <= 1'b0;
            bright_s <= '0;
        end else if (Enable && frame_start) begin
            data_s   <= Disp_Data;
            dp_s     <= Dp_Mask;
            blank_s  <= Blank_Mask;
            lz_s     <= Lz_En;
            bright_s <= Bright;
        end
    end

    // zrun[i]: every digit from i upward is a plain zero with no dp.
    always_comb begin
        logic run;
        run  = 1'b1;
        zrun = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run     = run && (data_s[i] == 4'h0) && !dp_s[i];
            zrun[i] = run;
        end
    end

    assign dark = blank_s | ({NUM_DIGITS{lz_s}} & zrun & ~NUM_DIGITS'(1));

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .nib (data_s[g]),
            .dp  (dp_s[g]),
            .seg (dig_seg[g])
        );
    end

    assign lit = (state == ON) && !dark[dig_idx];

    // SEL and SEG update together, so segments never switch under another digit's enable.
    always_ff @(posedge Clk) begin
        if (Reset || !Enable) begin
            SEL        <= SEL_OFF;
            SEG        <= SEG_OFF;
            Frame_Done <= 1'b0;
        end else begin
            SEL        <= lit ? ((NUM_DIGITS'(1) << dig_idx) ^ SEL_OFF) : SEL_OFF;
            SEG        <= lit ? dig_seg[dig_idx] : SEG_OFF;
            Frame_Done <= slot_end && (dig_idx == IW'(NUM_DIGITS - 1));
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position model plus directed literal checks.
module tb_seg7_scan_ctrl;
    localparam int ND = 4, GAPC = 2, PHC = 1;
    localparam int SLOTC = GAPC + 16 * PHC;
    localparam int FRAMEC = SLOTC * ND;

    logic        clk = 1'b0;
    logic        Reset, Enable, Lz_En;
    logic [15:0] Disp_Data;
    logic [3:0]  Dp_Mask, Blank_Mask, Bright, SEL;
    logic [7:0]  SEG;
    logic        Frame_Done;

    int n_cmp = 0, n_bad = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .GAP_CYCLES(GAPC), .PHASE_CYCLES(PHC)) dut (
        .Clk(clk), .Reset(Reset), .Enable(Enable), .Disp_Data(Disp_Data),
        .Dp_Mask(Dp_Mask), .Blank_Mask(Blank_Mask), .Lz_En(Lz_En), .Bright(Bright),
        .SEL(SEL), .SEG(SEG), .Frame_Done(Frame_Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: output = f(frame position, snapshot) ----------------
    logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blank, m_bright;
    logic        m_lz;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic        exp_fd;
    bit          chk_on = 0;
    int          k, pos, dig, s;
    bit          m_lit;

    function automatic bit model_dark(input int d);
        bit z = 1;
        if (m_blank[d]) return 1;
        if (!m_lz || d == 0) return 0;
        for (int j = d; j < ND; j++)
            if (m_data[4*j +: 4] != 4'h0 || m_dp[j]) z = 0;
        return z;
    endfunction

    always @(posedge clk) begin
        if (Reset) begin
            m_data = '0; m_dp = '0; m_blank = '0; m_bright = '0; m_lz = 0;
            chk_on = 1;
        end
        if (Reset || !Enable) begin
            exp_sel = 4'b0; exp_seg = 8'hFF; exp_fd = 0; k = 0;
        end else begin
            pos = k % FRAMEC; dig = pos / SLOTC; s = pos % SLOTC;
            if (pos == 0) begin
                m_data = Disp_Data; m_dp = Dp_Mask; m_blank = Blank_Mask;
                m_bright = Bright; m_lz = Lz_En;
            end
            m_lit = (s >= GAPC) && ((s - GAPC) / PHC < int'(m_bright) + 1) && !model_dark(dig);
            exp_sel = m_lit ? 4'(1 << dig) : 4'b0;
            exp_seg = m_lit ? {~m_dp[dig], tbl[m_data[4*dig +: 4]]} : 8'hFF;
            exp_fd  = (pos == FRAMEC - 1);
            k++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("SEL", SEL, exp_sel);
            chk("Frame_Done", Frame_Done, exp_fd);
            if (exp_sel != 0) chk("SEG", SEG, exp_seg);
        end
    end

    // ---------------- directed helpers (all bounded) ----------------
    task automatic wait_sel(input logic [3:0] want, output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (SEL !== want && c < 300);
        if (SEL !== want) chk("wait_sel_timeout", SEL, want);
    endtask

    task automatic wait_fd(output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (Frame_Done !== 1'b1 && c < 300);
        if (Frame_Done !== 1'b1) chk("wait_fd_timeout", Frame_Done, 1);
    endtask

    task automatic run_len(output int c);
        logic [3:0] s0;
        s0 = SEL; c = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (SEL !== s0) break;
            c++;
        end
    endtask

    task automatic scan_frame(output logic [3:0] m);
        int c;
        m = '0; c = 0;
        do begin @(negedge clk); m |= SEL; c++; end while (Frame_Done !== 1'b1 && c < 300);
        if (Frame_Done !== 1'b1) chk("scan_frame_timeout", Frame_Done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        logic [3:0] m;
        Reset = 1; Enable = 1; Disp_Data = 16'h1234; Dp_Mask = 0; Blank_Mask = 0;
        Lz_En = 0; Bright = 4'd15;
        repeat (2) @(negedge clk);
        chk("rst_SEL", SEL, 4'b0000);
        chk("rst_SEG", SEG, 8'hFF);
        chk("rst_FD", Frame_Done, 0);
        Reset = 0;

        // 1234 at full brightness
        wait_sel(4'b0001, c); chk("first_lit_delay", c, 3); chk("d0_seg", SEG, 8'h99);
        run_len(c);           chk("bright15_len", c, 16);
        wait_sel(4'b0010, c); chk("d1_seg", SEG, 8'hB0);
        wait_sel(4'b0100, c); chk("d2_seg", SEG, 8'hA4);
        wait_sel(4'b1000, c); chk("d3_seg", SEG, 8'hF9);
        wait_fd(c);
        wait_fd(c);           chk("frame_len", c, FRAMEC);

        // mid-frame data change must not tear the frame
        wait_sel(4'b0010, c); Disp_Data = 16'hABCD;
        wait_sel(4'b0100, c); chk("tear_d2", SEG, 8'hA4);
        wait_sel(4'b1000, c); chk("tear_d3", SEG, 8'hF9);
        wait_fd(c);
        wait_sel(4'b0001, c); chk("new_d0", SEG, 8'hA1);
        wait_sel(4'b0010, c); chk("new_d1", SEG, 8'hC6);
        wait_sel(4'b0100, c); chk("new_d2", SEG, 8'h83);
        wait_sel(4'b1000, c); chk("new_d3", SEG, 8'h88);

        // leading-zero blanking
        Lz_En = 1; Disp_Data = 16'h0050;
        wait_fd(c); scan_frame(m); chk("lz0050_mask", m, 4'b0011);
        wait_sel(4'b0010, c); chk("lz0050_d1", SEG, 8'h92);
        wait_sel(4'b0001, c); chk("lz0050_d0", SEG, 8'hC0);
        Disp_Data = 16'h0000;
        wait_fd(c); scan_frame(m); chk("lz0000_mask", m, 4'b0001);
        wait_sel(4'b0001, c); chk("lz0000_d0", SEG, 8'hC0);
        Dp_Mask = 4'b0100;
        wait_fd(c); scan_frame(m); chk("lzdp_mask", m, 4'b0111);
        wait_sel(4'b0100, c); chk("lzdp_d2", SEG, 8'h40);
        wait_sel(4'b0010, c); chk("lzdp_d1", SEG, 8'hC0);

        // brightness 3 and a blanked digit
        Lz_En = 0; Dp_Mask = 0; Disp_Data = 16'h1234; Bright = 4'd3; Blank_Mask = 4'b0010;
        wait_fd(c); scan_frame(m); chk("blank_mask", m, 4'b1101);
        wait_sel(4'b0001, c); run_len(c); chk("bright3_len", c, 4);

        // reset mid-ON
        wait_sel(4'b0100, c); Reset = 1;
        @(negedge clk);
        chk("midrst_SEL", SEL, 4'b0000); chk("midrst_SEG", SEG, 8'hFF);
        chk("midrst_FD", Frame_Done, 0);
        Reset = 0;
        wait_sel(4'b0001, c); chk("rst_restart_delay", c, 3);

        // Enable drop mid-ON; new data picked up on restart
        wait_sel(4'b0100, c); Enable = 0; Disp_Data = 16'hABCD;
        @(negedge clk);
        chk("dis_SEL", SEL, 4'b0000); chk("dis_SEG", SEG, 8'hFF);
        chk("dis_FD", Frame_Done, 0);
        @(negedge clk);
        Enable = 1;
        wait_sel(4'b0001, c); chk("en_restart_delay", c, 3); chk("en_new_d0", SEG, 8'hA1);

        wait_fd(c);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
